icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache between the fetcher and the memory controller.
- Serves fetch requests on a hit with 1-cycle latency.
- On a miss, issues one instruction fetch to the memory controller, fills the line from the returned instruction, and forwards the instruction to the fetcher.
- Line granularity is one instruction, either a full 32-bit word or a zero-extended compressed halfword, as returned by the memory controller.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (default 16 lines).
- XLEN, 32 (from global_params), address and data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state frozen when low
- flush  in  1  branch-mispredict flush
- stall  in  1  downstream stall; hold pending output
- fet_icache_enable  in  1  fetch request strobe, valid only while icache_busy low
- fet_pc  in  XLEN  request PC, halfword aligned
- icache_busy  out  1  state != IDLE
- icache_inst_ready  out  1  instruction valid to fetcher
- icache_inst  out  XLEN  instruction
- icache_inst_addr  out  XLEN  PC of icache_inst
- icache_mem_enable  out  1  fetch request to memory controller (drives fet_mem_enable)
- icache_mem_pc  out  XLEN  miss PC (drives fet_pc)
- mem_fet_busy  in  1  memory controller busy
- mem_inst_ready  in  1  memory returned instruction
- mem_inst  in  XLEN  returned instruction
- mem_inst_addr  in  XLEN  PC of returned instruction

Behaviour:
- Address split: index = pc[INDEX_WIDTH:1], tag = pc[XLEN-1:INDEX_WIDTH+1]. Storage per line: valid, tag, data[XLEN].
- Reset: all valid bits 0, state IDLE. All outputs 0: icache_inst_ready, icache_inst, icache_inst_addr, icache_mem_enable, icache_mem_pc.
- When rdy is low, nothing changes.
- IDLE, request accepted (fet_icache_enable and not flush):
  - Lookup is combinational from the arrays in the same cycle.
  - Hit: next cycle icache_inst_ready=1, icache_inst=data, icache_inst_addr=fet_pc; stay IDLE.
  - Miss: latch miss_pc=fet_pc and go to REQ.
- REQ: drive icache_mem_enable=1 and icache_mem_pc=miss_pc in the first cycle where mem_fet_busy=0. Exactly one cycle of enable, then go to WAIT and clear seen_busy.
- WAIT:
  - seen_busy is set on any cycle with mem_fet_busy=1.
  - Fill condition: seen_busy and mem_inst_ready and mem_inst_addr==miss_pc.
  - On fill: write line (valid=1, tag, data=mem_inst); next cycle icache_inst_ready=1 with mem_inst / miss_pc; go to IDLE.
  - mem_inst_ready may stay high for several cycles; capture only once.
- Output hold: icache_inst_ready is a one-cycle pulse when stall=0. While stall=1 it, icache_inst and icache_inst_addr hold. icache_busy stays 1 while a held output is pending, so no new request is accepted.
- Flush, any state:
  - Go to IDLE, icache_inst_ready<=0, icache_mem_enable<=0.
  - No fill is performed and the valid bits are kept.
  - A request presented in the same cycle as flush is ignored.
- A request arriving while a held output is pending is not accepted (busy).
- Same-index fill overwrites the previous line unconditionally.
- Reset mid-miss: reset wins and the outstanding memory response is ignored, since the state is IDLE.

Decomposition:
- Shared package / global_params: XLEN, ICACHE_INDEX_WIDTH, state encodings ICACHE_IDLE=2'd0, ICACHE_REQ=2'd1, ICACHE_WAIT=2'd2.
- No sub-module needed. The tag/data arrays are plain register arrays inside the icache module.

Test Plan:
- Reset, then request fet_pc=0x0000_0100, memory returns 0x0000_0513 -> exactly one icache_mem_enable with pc 0x100; icache_inst_ready one cycle later with inst 0x0000_0513, addr 0x100.
- Repeat fet_pc=0x100 -> no icache_mem_enable; icache_inst_ready on the next cycle with 0x0000_0513.
- Compressed instruction: fet_pc=0x102, memory returns 0x0000_4501 -> filled at index 1; a re-request hits with 0x0000_4501.
- Conflict: fill 0x100, then request 0x140 (same index 0, INDEX_WIDTH=4 on bits [4:1]) -> miss and refill. Re-requesting 0x100 then misses again.
- Flush in WAIT before mem_inst_ready -> state IDLE, no icache_inst_ready, line not valid; a later request to the same PC misses.
- stall=1 during a hit response -> icache_inst_ready, icache_inst and icache_inst_addr held for 3 cycles while icache_busy=1; the pulse clears the cycle after stall drops.
- mem_fet_busy=1 from an LSB access during REQ -> icache_mem_enable is delayed until busy drops, then asserted for exactly one cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

   localparam int XLEN               = 32;
   localparam int ICACHE_INDEX_WIDTH = 4;

   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_REQ  = 2'd1,
      ICACHE_WAIT = 2'd2
   } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: one instruction per line, 1-cycle hits,
// single-request miss handling toward the memory controller.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            flush,
   input  logic            stall,
   input  logic            fet_icache_enable,
   input  logic [XLEN-1:0] fet_pc,
   output logic            icache_busy,
   output logic            icache_inst_ready,
   output logic [XLEN-1:0] icache_inst,
   output logic [XLEN-1:0] icache_inst_addr,
   output logic            icache_mem_enable,
   output logic [XLEN-1:0] icache_mem_pc,
   input  logic            mem_fet_busy,
   input  logic            mem_inst_ready,
   input  logic [XLEN-1:0] mem_inst,
   input  logic [XLEN-1:0] mem_inst_addr
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = XLEN - INDEX_WIDTH - 1;

   icache_state_e          state_q, state_d;
   logic [XLEN-1:0]        miss_pc_q, miss_pc_d;
   logic                   seen_busy_q, seen_busy_d;
   logic                   inst_ready_q, inst_ready_d;
   logic [XLEN-1:0]        inst_q, inst_d;
   logic [XLEN-1:0]        inst_addr_q, inst_addr_d;
   logic                   mem_enable_q, mem_enable_d;
   logic [XLEN-1:0]        mem_pc_q, mem_pc_d;

   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [XLEN-1:0]        data_q [LINES];

   logic [INDEX_WIDTH-1:0] req_idx_s, fill_idx_s;
   logic [TAG_W-1:0]       req_tag_s, fill_tag_s;
   logic                   hold_s, hit_s, fill_s;
   logic                   unused_pc_lsb_s;

   assign req_idx_s       = fet_pc[INDEX_WIDTH:1];
   assign req_tag_s       = fet_pc[XLEN-1:INDEX_WIDTH+1];
   assign fill_idx_s      = miss_pc_q[INDEX_WIDTH:1];
   assign fill_tag_s      = miss_pc_q[XLEN-1:INDEX_WIDTH+1];
   assign unused_pc_lsb_s = fet_pc[0] ^ miss_pc_q[0];

   // A response stalled by the fetcher keeps the cache busy until it is taken.
   assign hold_s = inst_ready_q & stall;
   assign hit_s  = valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);

   assign icache_busy       = (state_q != ICACHE_IDLE) | hold_s;
   assign icache_inst_ready = inst_ready_q;
   assign icache_inst       = inst_q;
   assign icache_inst_addr  = inst_addr_q;
   assign icache_mem_enable = mem_enable_q;
   assign icache_mem_pc     = mem_pc_q;

   // Next-state, response and memory-request logic.
   always_comb begin
      state_d      = state_q;
      miss_pc_d    = miss_pc_q;
      seen_busy_d  = seen_busy_q;
      inst_ready_d = hold_s;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;
      mem_enable_d = 1'b0;
      mem_pc_d     = mem_pc_q;
      fill_s       = 1'b0;
      if (flush) begin
         state_d      = ICACHE_IDLE;
         inst_ready_d = 1'b0;
      end else begin
         case (state_q)
            ICACHE_IDLE: begin
               if (fet_icache_enable && !hold_s) begin
                  if (hit_s) begin
                     inst_ready_d = 1'b1;
                     inst_d       = data_q[req_idx_s];
                     inst_addr_d  = fet_pc;
                  end else begin
                     miss_pc_d = fet_pc;
                     state_d   = ICACHE_REQ;
                  end
               end else begin
                  state_d = ICACHE_IDLE;
               end
            end
            ICACHE_REQ: begin
               if (!mem_fet_busy) begin
                  mem_enable_d = 1'b1;
                  mem_pc_d     = miss_pc_q;
                  seen_busy_d  = 1'b0;
                  state_d      = ICACHE_WAIT;
               end else begin
                  state_d = ICACHE_REQ;
               end
            end
            ICACHE_WAIT: begin
               seen_busy_d = seen_busy_q | mem_fet_busy;
               // Only a response after the controller went busy belongs to our request.
               if (seen_busy_q && mem_inst_ready && (mem_inst_addr == miss_pc_q)) begin
                  fill_s       = 1'b1;
                  inst_ready_d = 1'b1;
                  inst_d       = mem_inst;
                  inst_addr_d  = miss_pc_q;
                  state_d      = ICACHE_IDLE;
               end else begin
                  state_d = ICACHE_WAIT;
               end
            end
            default: begin
               state_d = ICACHE_IDLE;
            end
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ICACHE_IDLE;
         miss_pc_q    <= {XLEN{1'b0}};
         seen_busy_q  <= 1'b0;
         inst_ready_q <= 1'b0;
         inst_q       <= {XLEN{1'b0}};
         inst_addr_q  <= {XLEN{1'b0}};
         mem_enable_q <= 1'b0;
         mem_pc_q     <= {XLEN{1'b0}};
         valid_q      <= {LINES{1'b0}};
      end else if (rdy) begin
         state_q      <= state_d;
         miss_pc_q    <= miss_pc_d;
         seen_busy_q  <= seen_busy_d;
         inst_ready_q <= inst_ready_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
         mem_enable_q <= mem_enable_d;
         mem_pc_q     <= mem_pc_d;
         if (fill_s) begin
            valid_q[fill_idx_s] <= 1'b1;
         end
      end
   end

   // Tag and data arrays; contents are qualified by valid_q.
   always_ff @(posedge clk) begin
      if (rdy && !rst && fill_s) begin
         tag_q[fill_idx_s]  <= fill_tag_s;
         data_q[fill_idx_s] <= mem_inst;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, stall, fet_icache_enable;
   logic [31:0] fet_pc;
   logic        icache_busy, icache_inst_ready, icache_mem_enable;
   logic [31:0] icache_inst, icache_inst_addr, icache_mem_pc;
   logic        mem_fet_busy, mem_inst_ready;
   logic [31:0] mem_inst, mem_inst_addr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   icache dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .flush             (flush),
      .stall             (stall),
      .fet_icache_enable (fet_icache_enable),
      .fet_pc            (fet_pc),
      .icache_busy       (icache_busy),
      .icache_inst_ready (icache_inst_ready),
      .icache_inst       (icache_inst),
      .icache_inst_addr  (icache_inst_addr),
      .icache_mem_enable (icache_mem_enable),
      .icache_mem_pc     (icache_mem_pc),
      .mem_fet_busy      (mem_fet_busy),
      .mem_inst_ready    (mem_inst_ready),
      .mem_inst          (mem_inst),
      .mem_inst_addr     (mem_inst_addr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Present a request for one cycle; returns at the negedge after acceptance.
   task automatic request(input logic [31:0] pc);
      fet_icache_enable = 1'b1;
      fet_pc            = pc;
      step();
      fet_icache_enable = 1'b0;
   endtask

   task automatic wait_enable(input string tag, input logic [31:0] pc);
      int n;
      n = 0;
      while (icache_mem_enable !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_eq({tag, "_mem_en"}, {31'd0, icache_mem_enable}, 32'd1);
      check_eq({tag, "_mem_pc"}, icache_mem_pc, pc);
   endtask

   // Memory side of a miss: busy for two cycles, then a response held two cycles.
   task automatic serve(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      wait_enable(tag, pc);
      mem_fet_busy = 1'b1;
      step();
      check_eq({tag, "_one_en"}, {31'd0, icache_mem_enable}, 32'd0);
      step();
      mem_fet_busy   = 1'b0;
      mem_inst_ready = 1'b1;
      mem_inst       = inst;
      mem_inst_addr  = pc;
      step();
      check_eq({tag, "_rdy"}, {31'd0, icache_inst_ready}, 32'd1);
      check_eq({tag, "_inst"}, icache_inst, inst);
      check_eq({tag, "_addr"}, icache_inst_addr, pc);
      step();
      check_eq({tag, "_pulse"}, {31'd0, icache_inst_ready}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, icache_busy}, 32'd0);
      mem_inst_ready = 1'b0;
   endtask

   task automatic miss(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      request(pc);
      check_eq({tag, "_miss_busy"}, {31'd0, icache_busy}, 32'd1);
      check_eq({tag, "_miss_rdy"}, {31'd0, icache_inst_ready}, 32'd0);
      serve(tag, pc, inst);
   endtask

   task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      request(pc);
      check_eq({tag, "_rdy"}, {31'd0, icache_inst_ready}, 32'd1);
      check_eq({tag, "_inst"}, icache_inst, inst);
      check_eq({tag, "_addr"}, icache_inst_addr, pc);
      check_eq({tag, "_no_mem"}, {31'd0, icache_mem_enable}, 32'd0);
      check_eq({tag, "_state"}, {31'd0, icache_busy}, 32'd0);
      step();
      check_eq({tag, "_pulse"}, {31'd0, icache_inst_ready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0;
      fet_icache_enable = 1'b0; fet_pc = 32'd0;
      mem_fet_busy = 1'b0; mem_inst_ready = 1'b0;
      mem_inst = 32'd0; mem_inst_addr = 32'd0;
      step();
      step();
      check_eq("rst_rdy",   {31'd0, icache_inst_ready}, 32'd0);
      check_eq("rst_inst",  icache_inst, 32'd0);
      check_eq("rst_addr",  icache_inst_addr, 32'd0);
      check_eq("rst_mem_en", {31'd0, icache_mem_enable}, 32'd0);
      check_eq("rst_mem_pc", icache_mem_pc, 32'd0);
      check_eq("rst_busy",  {31'd0, icache_busy}, 32'd0);
      rst = 1'b0;
      step();

      miss("m100", 32'h0000_0100, 32'h0000_0513);
      hit("h100", 32'h0000_0100, 32'h0000_0513);
      miss("m102", 32'h0000_0102, 32'h0000_4501);
      hit("h102", 32'h0000_0102, 32'h0000_4501);
      hit("h100b", 32'h0000_0100, 32'h0000_0513);

      // 0x140 shares index 0 with 0x100
      miss("m140", 32'h0000_0140, 32'h00A0_0093);
      hit("h140", 32'h0000_0140, 32'h00A0_0093);
      miss("m100c", 32'h0000_0100, 32'h0000_0513);

      // Flush while waiting for memory; late response must be ignored
      request(32'h0000_0184);
      wait_enable("fl", 32'h0000_0184);
      mem_fet_busy = 1'b1;
      step();
      mem_fet_busy = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("fl_busy", {31'd0, icache_busy}, 32'd0);
      check_eq("fl_rdy",  {31'd0, icache_inst_ready}, 32'd0);
      check_eq("fl_mem_en", {31'd0, icache_mem_enable}, 32'd0);
      mem_inst_ready = 1'b1; mem_inst = 32'h0000_0013; mem_inst_addr = 32'h0000_0184;
      step();
      check_eq("fl_late1", {31'd0, icache_inst_ready}, 32'd0);
      step();
      check_eq("fl_late2", {31'd0, icache_inst_ready}, 32'd0);
      mem_inst_ready = 1'b0;
      miss("m184", 32'h0000_0184, 32'h0000_0013);

      // Stalled hit response held for three cycles; a request meanwhile is refused
      stall = 1'b1;
      request(32'h0000_0100);
      for (int i = 0; i < 3; i++) begin
         check_eq("st_rdy",  {31'd0, icache_inst_ready}, 32'd1);
         check_eq("st_inst", icache_inst, 32'h0000_0513);
         check_eq("st_addr", icache_inst_addr, 32'h0000_0100);
         check_eq("st_busy", {31'd0, icache_busy}, 32'd1);
         if (i == 1) begin
            fet_icache_enable = 1'b1;
            fet_pc = 32'h0000_0102;
         end else begin
            fet_icache_enable = 1'b0;
         end
         if (i == 2) stall = 1'b0;
         step();
      end
      fet_icache_enable = 1'b0;
      check_eq("st_clear", {31'd0, icache_inst_ready}, 32'd0);
      check_eq("st_idle",  {31'd0, icache_busy}, 32'd0);

      // Controller busy during REQ delays the enable
      mem_fet_busy = 1'b1;
      request(32'h0000_0108);
      for (int i = 0; i < 3; i++) begin
         check_eq("rb_no_en", {31'd0, icache_mem_enable}, 32'd0);
         step();
      end
      mem_fet_busy = 1'b0;
      serve("rb", 32'h0000_0108, 32'h1234_5678);

      // rdy low freezes everything
      rdy = 1'b0;
      request(32'h0000_0108);
      check_eq("rdy_frozen", {31'd0, icache_inst_ready}, 32'd0);
      rdy = 1'b1;
      hit("h108", 32'h0000_0108, 32'h1234_5678);

      // Request coincident with flush is dropped
      flush = 1'b1;
      request(32'h0000_0108);
      flush = 1'b0;
      check_eq("fl_req_rdy",  {31'd0, icache_inst_ready}, 32'd0);
      check_eq("fl_req_busy", {31'd0, icache_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
